// File: rtl/alu_mult_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   ALU_WIDTH : default datapath width of the RISC ALU
//   mult_state_e : multiplier sequencer states (encodings fixed for debug visibility)
package alu_mult_seq_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of fulladder cells.
//   a, b : addends (WIDTH bits)
//   cin  : carry into bit 0
//   sum  : WIDTH-bit sum
//   cout : carry out of the top bit
module rca_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/alu_mult_seq.sv
// Multi-cycle shift-add multiplier: one partial product per clock through a
// WIDTH-bit ripple-carry adder, sign fix-up applied once at the end.
//   clk, rst  : clock and asynchronous active-high reset
//   start     : operation request, accepted in IDLE or DONE
//   is_signed : 1 = two's-complement operands (sampled with start)
//   a, b      : multiplicand / multiplier (sampled with start)
//   busy      : high while RUN or FIX
//   done      : one-cycle pulse, product valid
//   product   : 2*WIDTH-bit result, held until the next result is ready
// CNT_W must satisfy 2^CNT_W > WIDTH so the counter can hold WIDTH.
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;

    mult_state_e      state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [WIDTH-1:0] acc_hi_q,  acc_hi_d;
    logic             neg_q,     neg_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   step_hi;
    logic [PW-1:0]    acc_full;

    // Partial-product adder: acc_hi + mcand, carry kept as bit WIDTH
    rca_adder #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a    (acc_hi_q),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (is_signed && a[WIDTH-1]) a_mag = WIDTH'(~a + WIDTH'(1));
        if (is_signed && b[WIDTH-1]) b_mag = WIDTH'(~b + WIDTH'(1));
    end

    // Conditional add for the current multiplier LSB, before the right shift
    always_comb begin
        step_hi  = mplier_q[0] ? {add_cout, add_sum} : {1'b0, acc_hi_q};
        acc_full = {acc_hi_q, mplier_q};
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_hi_q  <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_hi_q  <= acc_hi_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_hi_d  = acc_hi_q;
        neg_d     = neg_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) state_d = ST_IDLE;
                if (start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_hi_d = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Shift {carry, acc_hi, multiplier} right by one
                acc_hi_d = step_hi[WIDTH:1];
                mplier_d = {step_hi[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                product_d = neg_q ? PW'(~acc_full + PW'(1)) : acc_full;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed self-checking bench for alu_mult_seq (WIDTH = 32).
module tb_alu_mult_seq;

    localparam int unsigned W = 32;
    localparam int LAT = W + 1;   // edges from accept edge to first cycle with done

    logic           clk;
    logic           rst;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_mult_seq #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then release start.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg);
        a = av;
        b = bv;
        is_signed = sg;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 'x;
        b = 'x;
        is_signed = 1'bx;
    endtask

    // Advance until done (bounded); report edges taken and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cyc++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        #1;
        total_cnt++;
        if ({busy, done, product} !== {2'b00, 64'd0})
            $display("FAIL reset_state: busy=%b done=%b product=%h, want 0/0/0", busy, done, product);
        else pass_cnt++;
        repeat (2) tick();
        #2 rst = 1'b0;
        tick();
        total_cnt++;
        if ({busy, done, product} !== {2'b00, 64'd0})
            $display("FAIL reset_release: busy=%b done=%b product=%h, want 0/0/0", busy, done, product);
        else pass_cnt++;
    endtask

    task automatic test_unsigned_small();
        int lat, bc;
        issue(32'd3, 32'd5, 1'b0);
        wait_done(lat, bc);
        total_cnt++;
        if (lat !== LAT) $display("FAIL latency_3x5: %0d edges, want %0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (bc !== LAT) $display("FAIL busy_cycles_3x5: %0d, want %0d", bc, LAT);
        else pass_cnt++;
        total_cnt++;
        if (product !== 64'h0000_0000_0000_000F || busy !== 1'b0)
            $display("FAIL product_3x5: product=%h busy=%b, want 000000000000000f busy=0", product, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || product !== 64'h0000_0000_0000_000F)
            $display("FAIL done_pulse_3x5: done=%b product=%h, want done=0 product held", done, product);
        else pass_cnt++;
    endtask

    task automatic test_unsigned_max();
        int lat, bc;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'hFFFF_FFFE_0000_0001)
            $display("FAIL umax: product=%h, want fffffffe00000001", product);
        else pass_cnt++;
        tick();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'h0000_0000_0000_0001)
            $display("FAIL smin1_sq: product=%h, want 0000000000000001", product);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_signed();
        int lat, bc;
        issue(32'hFFFF_FFF9, 32'd6, 1'b1);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFD6)
            $display("FAIL neg7x6: product=%h, want ffffffffffffffd6", product);
        else pass_cnt++;
        tick();
        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'h4000_0000_0000_0000)
            $display("FAIL smin_sq: product=%h, want 4000000000000000", product);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_busy_start();
        int lat, bc;
        issue(32'd2, 32'd4, 1'b0);
        repeat (3) tick();
        total_cnt++;
        if (product !== 64'h4000_0000_0000_0000 || busy !== 1'b1)
            $display("FAIL hold_during_run: product=%h busy=%b, want 4000000000000000 busy=1", product, busy);
        else pass_cnt++;
        a = 32'd9;
        b = 32'd9;
        is_signed = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'd8 || lat !== LAT - 4)
            $display("FAIL busy_start_ignored: product=%h lat=%0d, want 8 lat=%0d", product, lat, LAT - 4);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_zero();
        int lat, bc;
        issue(32'd0, 32'h1234_5678, 1'b0);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'd0) $display("FAIL zero_u: product=%h, want 0", product);
        else pass_cnt++;
        tick();
        issue(32'd0, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'd0) $display("FAIL zero_s_neg: product=%h, want 0", product);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(32'd6, 32'd7, 1'b0);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'd42) $display("FAIL b2b_first: product=%h, want 2a", product);
        else pass_cnt++;
        a = 32'd10;
        b = 32'd10;
        is_signed = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
        else pass_cnt++;
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'd100 || lat !== LAT)
            $display("FAIL b2b_second: product=%h lat=%0d, want 64 lat=%0d", product, lat, LAT);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        issue(32'd5, 32'd5, 1'b0);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, product} !== {2'b00, 64'd0})
            $display("FAIL async_reset: busy=%b done=%b product=%h, want 0/0/0", busy, done, product);
        else pass_cnt++;
        tick();
        #2 rst = 1'b0;
        repeat (40) begin
            tick();
            total_cnt++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL abandoned_op: done=%b busy=%b, want 0/0", done, busy);
            else pass_cnt++;
        end
        issue(32'd7, 32'd7, 1'b0);
        wait_done(lat, bc);
        total_cnt++;
        if (product !== 64'h31 || lat !== LAT)
            $display("FAIL post_reset_7x7: product=%h lat=%0d, want 31 lat=%0d", product, lat, LAT);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned_small();
        test_unsigned_max();
        test_signed();
        test_busy_start();
        test_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
